// File: rtl/reset_sequencer_if.sv
// Reset-stream bundle between the reset sequencer and the logic it controls:
// software reset request in, per-domain resets and assertion enable out.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   sw_reset_req;
    logic [NUM_DOMAINS-1:0] domain_reset;
    logic                   assert_en;
    logic                   seq_busy;

    modport master (
        input  sw_reset_req,
        output domain_reset,
        output assert_en,
        output seq_busy
    );

    modport slave (
        output sw_reset_req,
        input  domain_reset,
        input  assert_en,
        input  seq_busy
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: asynchronous assert, synchronised release, fixed hold, then
// ordered per-domain release; assert_en rises once every domain is out of reset.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    reset_sequencer_if.master seq
);
    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_rst_n;
    logic [CNT_W-1:0]       hold_cnt_reg;
    logic [CNT_W-1:0]       gap_cnt_reg;
    logic [IDX_W-1:0]       dom_idx_reg;
    logic [NUM_DOMAINS-1:0] domain_reset_reg;
    logic                   assert_en_reg;
    logic                   seq_busy_reg;

    assign sync_rst_n = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= SYNC;
            sync_reg         <= '0;
            hold_cnt_reg     <= '0;
            gap_cnt_reg      <= '0;
            dom_idx_reg      <= '0;
            domain_reset_reg <= '1;
            assert_en_reg    <= 1'b0;
            seq_busy_reg     <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
            case (state_reg)
                // Leave SYNC on the same edge the last synchroniser stage goes high.
                SYNC: begin
                    if (sync_reg[SYNC_STAGES-2]) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= '0;
                    end
                end
                HOLD: begin
                    if (sync_rst_n) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            // Domains release lowest bit first, so one shift frees the next one.
                            domain_reset_reg <= domain_reset_reg << 1;
                            hold_cnt_reg     <= '0;
                            gap_cnt_reg      <= '0;
                            dom_idx_reg      <= '0;
                            state_reg        <= (NUM_DOMAINS == 1) ? RUN : RELEASE;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (seq.sw_reset_req) begin
                        state_reg        <= HOLD;
                        hold_cnt_reg     <= '0;
                        gap_cnt_reg      <= '0;
                        dom_idx_reg      <= '0;
                        domain_reset_reg <= '1;
                    end else if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg      <= '0;
                        dom_idx_reg      <= dom_idx_reg + 1'b1;
                        domain_reset_reg <= domain_reset_reg << 1;
                        if (dom_idx_reg == IDX_LAST - 1'b1) begin
                            state_reg <= RUN;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (seq.sw_reset_req) begin
                        state_reg        <= HOLD;
                        hold_cnt_reg     <= '0;
                        gap_cnt_reg      <= '0;
                        dom_idx_reg      <= '0;
                        domain_reset_reg <= '1;
                        assert_en_reg    <= 1'b0;
                        seq_busy_reg     <= 1'b1;
                    end else begin
                        assert_en_reg <= 1'b1;
                        seq_busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= SYNC;
            endcase
        end
    end

    assign seq.domain_reset = domain_reset_reg;
    assign seq.assert_en    = assert_en_reg;
    assign seq.seq_busy     = seq_busy_reg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default build plus a minimal one, driven together
// and checked every cycle against a timeline model of the release schedule.
module tb_reset_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    logic sw_req;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_DOMAINS(3)) bus0 ();
    reset_sequencer_if #(.NUM_DOMAINS(1)) bus1 ();

    assign bus0.sw_reset_req = sw_req;
    assign bus1.sw_reset_req = sw_req;

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_DOMAINS(3), .STAGE_GAP(4)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .seq     (bus0)
    );

    reset_sequencer #(
        .SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGE_GAP(1)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .seq     (bus1)
    );

    // Per-build parameters for the model.
    function automatic int p_ss(int d); return (d == 0) ? 2  : 3; endfunction
    function automatic int p_h (int d); return (d == 0) ? 16 : 1; endfunction
    function automatic int p_nd(int d); return (d == 0) ? 3  : 1; endfunction
    function automatic int p_g (int d); return (d == 0) ? 4  : 1; endfunction

    // Model: either waiting for synchronised release, or a timeline measured
    // from the edge on which the hold interval began.
    bit in_sync[2];
    int rise_cnt[2];
    int hold_start[2];
    int edge_n = 0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0] dr0;
        logic       ae0;
        logic       bz0;
        logic       dr1;
        logic       ae1;
        logic       bz1;
    } exp_t;
    exp_t exp_q[$];

    function automatic void model_async();
        for (int d = 0; d < 2; d++) begin
            in_sync[d]  = 1'b1;
            rise_cnt[d] = 0;
        end
    endfunction

    function automatic void model_edge(int d, logic rn, logic sw);
        if (!rn) begin
            in_sync[d]  = 1'b1;
            rise_cnt[d] = 0;
        end else if (in_sync[d]) begin
            rise_cnt[d]++;
            if (rise_cnt[d] >= p_ss(d)) begin
                in_sync[d]    = 1'b0;
                hold_start[d] = edge_n;
            end
        end else if (sw && (edge_n - 1 - hold_start[d]) >= p_h(d)) begin
            // Request counts only once at least one domain had been released.
            hold_start[d] = edge_n;
        end
    endfunction

    function automatic int exp_dr(int d);
        int mask = (1 << p_nd(d)) - 1;
        int k;
        int rel;
        if (in_sync[d]) return mask;
        k = edge_n - hold_start[d];
        if (k < p_h(d)) rel = 0;
        else            rel = 1 + (k - p_h(d)) / p_g(d);
        if (rel > p_nd(d)) rel = p_nd(d);
        return mask & ~((1 << rel) - 1);
    endfunction

    function automatic logic exp_ae(int d);
        if (in_sync[d]) return 1'b0;
        return (edge_n - hold_start[d]) >= p_h(d) + (p_nd(d) - 1) * p_g(d) + 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   v0;
        int   v1;
        v0    = exp_dr(0);
        v1    = exp_dr(1);
        e.dr0 = v0[2:0];
        e.ae0 = exp_ae(0);
        e.bz0 = !e.ae0;
        e.dr1 = v1[0];
        e.ae1 = exp_ae(1);
        e.bz1 = !e.ae1;
        return e;
    endfunction

    // One clock of stimulus: advance the model on the edge with the values the
    // DUTs sampled, then drive new inputs just after it and queue the outcome.
    task automatic cycle(input logic rn, input logic sw);
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) model_edge(d, reset_n, sw_req);
        #1;
        if (rn != reset_n || sw)
            $display("[%0t] edge %0d drive reset_n=%0b sw_reset_req=%0b", $time, edge_n, rn, sw);
        reset_n = rn;
        sw_req  = sw;
        if (!rn) model_async();
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    // Monitor: compare on the falling edge, well away from the active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({bus0.domain_reset, bus0.assert_en, bus0.seq_busy} !== {e.dr0, e.ae0, e.bz0}) begin
                    n_bad++;
                    $display("FAIL default_build edge %0d: dr=%b ae=%b busy=%b, required dr=%b ae=%b busy=%b",
                             edge_n, bus0.domain_reset, bus0.assert_en, bus0.seq_busy, e.dr0, e.ae0, e.bz0);
                end
                n_vec++;
                if ({bus1.domain_reset, bus1.assert_en, bus1.seq_busy} !== {e.dr1, e.ae1, e.bz1}) begin
                    n_bad++;
                    $display("FAIL minimal_build edge %0d: dr=%b ae=%b busy=%b, required dr=%b ae=%b busy=%b",
                             edge_n, bus1.domain_reset, bus1.assert_en, bus1.seq_busy, e.dr1, e.ae1, e.bz1);
                end
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0;
        sw_req  = 1'b0;
        model_async();

        // Power-on: low for 5 cycles, then rise between edges.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        run(40);

        // Asynchronous drop while running, then an identical re-sequence.
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        run(40);

        // Software reset in RUN.
        cycle(1'b1, 1'b1);
        // Request in HOLD (hold count 7) must be ignored.
        run(7);
        cycle(1'b1, 1'b1);
        run(40);

        // Request while domain_reset is 3'b100 restarts HOLD.
        cycle(1'b1, 1'b1);
        run(20);
        cycle(1'b1, 1'b1);
        // Request on the edge that would enter RUN.
        run(23);
        cycle(1'b1, 1'b1);
        run(40);

        // One-cycle reset_n glitch while domain_reset is 3'b110.
        cycle(1'b1, 1'b1);
        run(17);
        cycle(1'b0, 1'b0);
        run(40);

        // Randomised mix of idle cycles, software requests and reset drops.
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) cycle(1'b0, 1'b0);
            end else if (r < 7) begin
                cycle(1'b1, 1'b1);
            end else begin
                cycle(1'b1, 1'b0);
            end
        end
        run(40);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
